// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared state encoding and defaults for the UART ALU sequencer
package uart_alu_pkg;

  localparam int DEFAULT_SIZE_DATA      = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

endpackage

// File: rtl/byte_gap_timer.sv
// rtl/byte_gap_timer.sv - idle-cycle counter between received bytes with an expire pulse
module byte_gap_timer
  import uart_alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count;

  // A zero timeout parks the counter so expire can never fire.
  assign expire = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if ((TIMEOUT_CYCLES == 0) || clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - collects operand A, operand B and opcode from UART, sends the ALU result back
module uart_alu_sequencer
  import uart_alu_pkg::*;
#(
  parameter int SIZE_DATA      = DEFAULT_SIZE_DATA,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [SIZE_DATA-1:0] i_rx_data,
  input  logic [SIZE_DATA-1:0] i_alu_result,
  input  logic                 i_tx_done,
  output logic [SIZE_DATA-1:0] o_operandoA,
  output logic [SIZE_DATA-1:0] o_operandoB,
  output logic [SIZE_DATA-1:0] o_opcode,
  output logic [SIZE_DATA-1:0] o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_timeout
);

  state_t state;
  logic   gap_enable;
  logic   gap_clear;
  logic   gap_expire;

  assign gap_enable = (state == WAIT_B) || (state == WAIT_OP);
  assign gap_clear  = i_rx_done || (state == WAIT_A);

  byte_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk   (i_clk),
    .rst_n (i_reset),
    .clear (gap_clear),
    .enable(gap_enable),
    .expire(gap_expire)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= WAIT_A;
      o_operandoA <= '0;
      o_operandoB <= '0;
      o_opcode    <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        WAIT_A: begin
          if (i_rx_done) begin
            o_operandoA <= i_rx_data;
            state       <= WAIT_B;
          end
        end
        // A byte landing in the expiry cycle takes priority over the timeout.
        WAIT_B: begin
          if (i_rx_done) begin
            o_operandoB <= i_rx_data;
            state       <= WAIT_OP;
          end else if (gap_expire) begin
            o_timeout <= 1'b1;
            state     <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            o_opcode <= i_rx_data;
            o_busy   <= 1'b1;
            state    <= EXEC;
          end else if (gap_expire) begin
            o_timeout <= 1'b1;
            state     <= WAIT_A;
          end
        end
        EXEC: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= WAIT_A;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

- Sits directly upstream of the ALU operand/opcode holding stage, between the UART receiver and the UART transmitter.
- Sequences received bytes into operand A, operand B and opcode, in that order, and holds them on registered outputs for the ALU path.
- After the opcode arrives, captures the ALU result and hands it to the transmitter with a start pulse, then waits for transmit completion.
- Aborts a partial frame and returns to waiting for operand A if the gap between bytes exceeds a programmable timeout.

## Interface

Parameters:
- `SIZE_DATA`, default 8: width of every data byte, operand, opcode and result.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle clock cycles allowed between bytes of one frame. A value of 0 disables the timeout.

Ports:
- `i_clk`  in  1  — single system clock; all logic is on the rising edge.
- `i_reset`  in  1  — asynchronous, active-low reset.
- `i_rx_done`  in  1  — one-cycle pulse; `i_rx_data` is valid in that cycle.
- `i_rx_data`  in  SIZE_DATA  — received byte.
- `i_alu_result`  in  SIZE_DATA  — combinational ALU output, computed from `o_operandoA`, `o_operandoB` and `o_opcode`.
- `i_tx_done`  in  1  — one-cycle pulse from the transmitter when the byte has been sent.
- `o_operandoA`  out  SIZE_DATA  — held operand A.
- `o_operandoB`  out  SIZE_DATA  — held operand B.
- `o_opcode`  out  SIZE_DATA  — held opcode.
- `o_tx_data`  out  SIZE_DATA  — result byte for the transmitter.
- `o_tx_start`  out  1  — one-cycle transmit request.
- `o_busy`  out  1  — high in states EXEC and WAIT_TX.
- `o_timeout`  out  1  — one-cycle pulse when a partial frame is abandoned.

## Operation

- Reset (`i_reset` = 0): state = WAIT_A; all data outputs = 0; `o_tx_start`, `o_busy`, `o_timeout` = 0; timeout counter = 0.
- State machine:
  - WAIT_A: on `i_rx_done`, load `o_operandoA`, then go to WAIT_B.
  - WAIT_B: on `i_rx_done`, load `o_operandoB`, then go to WAIT_OP.
  - WAIT_OP: on `i_rx_done`, load `o_opcode`, then go to EXEC.
  - EXEC: lasts exactly one cycle. Register `o_tx_data <= i_alu_result`, pulse `o_tx_start`, then go to WAIT_TX.
  - WAIT_TX: on `i_tx_done`, go to WAIT_A. The `i_tx_done` pulse is honoured in any WAIT_TX cycle, including the cycle in which `o_tx_start` is high.
- `i_rx_done` is ignored (the byte is dropped) in EXEC and WAIT_TX. No buffering.
- Timeout counter, width `$clog2(TIMEOUT_CYCLES+1)`:
  - Counts only in WAIT_B and WAIT_OP.
  - Clears on every `i_rx_done` and on every entry to WAIT_A.
  - When it reaches TIMEOUT_CYCLES−1 with no `i_rx_done` in that cycle: pulse `o_timeout`, go to WAIT_A, clear the counter.
  - Operand and opcode outputs keep their last values on timeout; they are not zeroed.
- Boundary case: `i_rx_done` in the expiry cycle wins. The byte is captured, the frame advances and no timeout is raised.
- With TIMEOUT_CYCLES = 0 the counter is held at 0 and `o_timeout` never asserts.
- Outputs change only at capture edges, so the downstream holding stage sees stable values.

## Timing

- A byte is captured at the edge that closes its `i_rx_done` cycle N; the output shows the new value in cycle N+1.
- Opcode `i_rx_done` in cycle N: state is EXEC in cycle N+1, with `i_alu_result` settled from the new outputs. `o_tx_start` = 1 and `o_tx_data` are valid in cycle N+2.
- `o_tx_data` holds until the next EXEC.
- `o_busy` rises in cycle N+1 and falls in the cycle after the `i_tx_done` cycle.
- `o_timeout` is high for exactly one cycle, in the cycle when the state first reads WAIT_A again.
- Reset asserted mid-frame or mid-transmit: immediate, asynchronous return to reset values. A pending transmit is abandoned with no `o_tx_start` re-issue.

## Structure

- Shared package `uart_alu_pkg`:
  - state encoding localparams: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX (3 bits);
  - default SIZE_DATA;
  - default TIMEOUT_CYCLES.
- One sub-module, `byte_gap_timer`: counter with clear, enable and an expire pulse, parameterised by TIMEOUT_CYCLES. The top level holds the FSM and the output registers.

## Test plan

- Reset, then bytes 0x05, 0x03, 0x20 each with a one-cycle `i_rx_done`, and a behavioural ALU that adds → `o_operandoA`=0x05, `o_operandoB`=0x03, `o_opcode`=0x20; `o_tx_start` pulses 2 cycles after the third `i_rx_done` with `o_tx_data`=0x08.
- Extra byte 0xFF sent while in WAIT_TX, then `i_tx_done` → 0xFF is dropped; the next byte 0x11 loads `o_operandoA`.
- TIMEOUT_CYCLES=16: byte 0x0A, then 16 silent cycles → `o_timeout` pulses once; state returns to WAIT_A; `o_operandoA` stays 0x0A; the next byte loads A.
- TIMEOUT_CYCLES=16: second byte arrives exactly in the expiry cycle → no `o_timeout`; `o_operandoB` is loaded.
- `i_reset` driven low mid-frame (after A = 0x7E) and between clock edges → all outputs are 0 immediately; after release, a full 3-byte frame works normally.
- `i_tx_done` in the same cycle as `o_tx_start` → returns to WAIT_A on the next edge; `o_busy` is low in the cycle after.
